// File: rtl/adder_self_test.sv
// adder_self_test: self-test sequencer for the 4-bit adder datapath.
// It walks a synchronous vector ROM, drives each vector into the adder,
// waits SETTLE cycles, then compares {overflow, cout, sum} against the
// expected fields and accumulates mismatch statistics.
// Optional feature: define ADDER_SELF_TEST_STOP_ON_FAIL_EN to end the run
// at the first mismatching vector.
module adder_self_test #(
  parameter int NUM_VEC = 15,
  parameter int SETTLE  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [3:0]  vec_addr,
  input  logic [19:0] vec_data,
  output logic [3:0]  dut_a,
  output logic [3:0]  dut_b,
  output logic        dut_cin,
  input  logic [3:0]  dut_sum,
  input  logic        dut_cout,
  input  logic        dut_overfl,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic        fail_valid,
  output logic [3:0]  first_fail
);

`ifdef ADDER_SELF_TEST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [3:0] LAST     = 4'(NUM_VEC - 1);
  localparam logic [3:0] SETTLE_V = 4'(SETTLE);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_APPLY, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  // ROM word layout; the reserved field is carried but never used
  typedef struct packed {
    logic [4:0] rsvd;
    logic       ovf;
    logic       cout;
    logic [3:0] sum;
    logic       cin;
    logic [3:0] a;
    logic [3:0] b;
  } vec_t;

  // Adder response as compared in CHECK
  typedef struct packed {
    logic       ovf;
    logic       cout;
    logic [3:0] sum;
  } resp_t;

  state_t     state, next_state;
  vec_t       vw;
  resp_t      exp_q, got;
  logic [3:0] cnt_q;
  logic       mismatch;
  logic       unused_rsvd;

  assign vw          = vec_t'(vec_data);
  assign got         = '{ovf: dut_overfl, cout: dut_cout, sum: dut_sum};
  assign mismatch    = (got != exp_q);
  // Reserved ROM bits are intentionally ignored
  assign unused_rsvd = ^vw.rsvd;

  assign busy = (state == S_FETCH) || (state == S_APPLY) ||
                (state == S_SETTLE) || (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == 5'd0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE: if (start) next_state = S_FETCH;
      S_FETCH:        next_state = S_APPLY;
      S_APPLY:        next_state = S_SETTLE;
      S_SETTLE:       if (cnt_q == 4'd1) next_state = S_CHECK;
      S_CHECK: begin
        if (vec_addr == LAST || (STOP_ON_FAIL && mismatch)) next_state = S_DONE;
        else                                                next_state = S_FETCH;
      end
      default:        next_state = S_IDLE;
    endcase
  end

  // Datapath: address/index, adder drive, settle counter, statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_addr   <= '0;
      dut_a      <= '0;
      dut_b      <= '0;
      dut_cin    <= 1'b0;
      exp_q      <= '0;
      cnt_q      <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec_addr   <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
          end
        end
        S_APPLY: begin
          dut_a   <= vw.a;
          dut_b   <= vw.b;
          dut_cin <= vw.cin;
          exp_q   <= '{ovf: vw.ovf, cout: vw.cout, sum: vw.sum};
          cnt_q   <= SETTLE_V;
        end
        S_SETTLE: cnt_q <= cnt_q - 4'd1;
        S_CHECK: begin
          if (mismatch) begin
            if (err_count != 5'd31) err_count <= err_count + 5'd1;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              first_fail <= vec_addr;
            end
          end
          if (next_state == S_FETCH) vec_addr <= vec_addr + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
